// File: rtl/mem_client_port_pkg.sv
// mem_client_port_pkg
// Shared definitions for the SDRAM client side: the address field split
// {row, bank, column}, data width, default read latency and the request
// record that travels through the request FIFO.
package mem_client_port_pkg;

  // Address split: row [27:15], bank [14:13], column [12:0].
  localparam int ROW_W  = 13;
  localparam int BANK_W = 2;
  localparam int COL_W  = 13;
  localparam int ADDR_W = ROW_W + BANK_W + COL_W;

  localparam int WORD_W = 32;

  // Latch-to-valid read latency shared with the controller.
  localparam int RD_LAT_DEFAULT = 4;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
  } mem_addr_t;

  // Request body; the tag is appended separately because its width is a
  // parameter of the client.
  typedef struct packed {
    mem_addr_t         addr;
    logic              we;
    logic [WORD_W-1:0] wdata;
  } req_body_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo
// DEPTH-entry request FIFO with a separate occupancy count for full/empty.
// Ports:
//   CLK, RST   clock, synchronous active-low reset
//   push_i     write din_i (ignored when full, even if a pop happens too)
//   pop_i      drop the head entry (ignored when empty)
//   din_i      entry to write
//   dout_o     head entry (undefined while empty)
//   full_o     DEPTH entries held
//   empty_o    no entries held
module mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; an entry is only read after it was written,
  // and leaving reset off keeps the array a plain register file/RAM.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_client_port.sv
// mem_client_port
// Requester side of the SDRAM controller client handshake. Queues upstream
// requests, presents the head to the controller (DO_ACT/COMMAND_LATCHED),
// tracks in-flight reads through a fixed-latency pipeline, returns DATA_R
// with its tag, and toggles REFRESH_STROBE once per refresh period.
// Ports:
//   CLK, RST                    clock, synchronous active-low reset
//   REQ_VALID/READY/ADDR/WE/WDATA/TAG   upstream request handshake
//   ADDRESS_REQ, WE, DATA_W, DO_ACT     head request to the controller
//   COMMAND_LATCHED             controller accepted the head this cycle
//   DATA_R                      controller read data
//   RD_VALID, RD_DATA, RD_TAG   read return (one-cycle pulse)
//   REFRESH_STROBE              refresh toggle
//   BUSY                        queued or in-flight work present
//   PROTO_ERR                   sticky: latch seen with nothing offered
module mem_client_port
  import mem_client_port_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 4,
  parameter int RD_LAT         = RD_LAT_DEFAULT,
  parameter int REFRESH_PERIOD = 1560
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic              REQ_WE,
  input  logic [WORD_W-1:0] REQ_WDATA,
  input  logic [TAG_W-1:0]  REQ_TAG,
  output logic [ADDR_W-1:0] ADDRESS_REQ,
  output logic              WE,
  output logic [WORD_W-1:0] DATA_W,
  output logic              DO_ACT,
  input  logic              COMMAND_LATCHED,
  input  logic [WORD_W-1:0] DATA_R,
  output logic              RD_VALID,
  output logic [WORD_W-1:0] RD_DATA,
  output logic [TAG_W-1:0]  RD_TAG,
  output logic              REFRESH_STROBE,
  output logic              BUSY,
  output logic              PROTO_ERR
);

  localparam int ENTRY_W = $bits(req_body_t) + TAG_W;
  localparam int RW      = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  // ---------------- request FIFO ----------------
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  req_body_t          head;
  logic [TAG_W-1:0]   head_tag;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  assign fifo_din         = {REQ_ADDR, REQ_WE, REQ_WDATA, REQ_TAG};
  assign {head, head_tag} = fifo_dout;

  assign push = REQ_VALID && !fifo_full;
  assign pop  = DO_ACT && COMMAND_LATCHED;

  mem_req_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign REQ_READY   = !fifo_full;
  assign DO_ACT      = !fifo_empty;
  assign ADDRESS_REQ = head.addr;
  assign WE          = head.we;
  assign DATA_W      = head.wdata;

  // ---------------- read tracking ----------------
  // Stage k holds a read k edges after its latch edge; stage RD_LAT is the
  // last one, and the following edge captures DATA_R (RD_LAT+1 total).
  logic [RD_LAT:0]            rd_vld_q;
  logic [RD_LAT:0][TAG_W-1:0] rd_tag_q;
  logic                       rd_valid_q;
  logic [WORD_W-1:0]          rd_data_q;
  logic [TAG_W-1:0]           rd_tag_out_q;
  logic                       proto_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_vld_q     <= '0;
      rd_tag_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_tag_out_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      rd_vld_q   <= {rd_vld_q[RD_LAT-1:0], pop && !head.we};
      rd_tag_q   <= {rd_tag_q[RD_LAT-1:0], head_tag};
      rd_valid_q <= rd_vld_q[RD_LAT];
      if (rd_vld_q[RD_LAT]) begin
        rd_data_q    <= DATA_R;
        rd_tag_out_q <= rd_tag_q[RD_LAT];
      end
      // A latch with nothing offered is a controller bug; remember it.
      if (COMMAND_LATCHED && !DO_ACT) proto_err_q <= 1'b1;
    end
  end

  assign RD_VALID  = rd_valid_q;
  assign RD_DATA   = rd_data_q;
  assign RD_TAG    = rd_tag_out_q;
  assign PROTO_ERR = proto_err_q;
  assign BUSY      = !fifo_empty || (|rd_vld_q);

  // ---------------- refresh timer ----------------
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          strobe_q, strobe_d;

  // NOTE: defaults first so every path assigns each output; no latches.
  always_comb begin
    ref_cnt_d = ref_cnt_q + RW'(1);
    strobe_d  = strobe_q;
    if (ref_cnt_q == RW'(REFRESH_PERIOD - 1)) begin
      ref_cnt_d = '0;
      strobe_d  = !strobe_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ref_cnt_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      strobe_q  <= strobe_d;
    end
  end

  assign REFRESH_STROBE = strobe_q;

endmodule

// File: tb/tb_mem_client_port.sv
// tb_mem_client_port
// Directed stimulus with a reference model: each issued read pushes its
// expected {tag, data, cycle} into a scoreboard queue that an independent
// negedge monitor pops whenever RD_VALID is seen.
module tb_mem_client_port;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int RD_LAT = 4;
  localparam int RP     = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic [27:0]       REQ_ADDR = '0;
  logic              REQ_WE = 1'b0;
  logic [31:0]       REQ_WDATA = '0;
  logic [TAG_W-1:0]  REQ_TAG = '0;
  logic [27:0]       ADDRESS_REQ;
  logic              WE;
  logic [31:0]       DATA_W;
  logic              DO_ACT;
  logic              COMMAND_LATCHED = 1'b0;
  logic [31:0]       DATA_R = '0;
  logic              RD_VALID;
  logic [31:0]       RD_DATA;
  logic [TAG_W-1:0]  RD_TAG;
  logic              REFRESH_STROBE;
  logic              BUSY;
  logic              PROTO_ERR;

  mem_client_port #(
    .DEPTH          (DEPTH),
    .TAG_W          (TAG_W),
    .RD_LAT         (RD_LAT),
    .REFRESH_PERIOD (RP)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .REQ_VALID       (REQ_VALID),
    .REQ_READY       (REQ_READY),
    .REQ_ADDR        (REQ_ADDR),
    .REQ_WE          (REQ_WE),
    .REQ_WDATA       (REQ_WDATA),
    .REQ_TAG         (REQ_TAG),
    .ADDRESS_REQ     (ADDRESS_REQ),
    .WE              (WE),
    .DATA_W          (DATA_W),
    .DO_ACT          (DO_ACT),
    .COMMAND_LATCHED (COMMAND_LATCHED),
    .DATA_R          (DATA_R),
    .RD_VALID        (RD_VALID),
    .RD_DATA         (RD_DATA),
    .RD_TAG          (RD_TAG),
    .REFRESH_STROBE  (REFRESH_STROBE),
    .BUSY            (BUSY),
    .PROTO_ERR       (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  // Edge counter: after posedge E has settled, cyc == E.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [27:0]      addr;
    logic             we;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    int               due;
  } ret_t;

  req_t fq[$];
  ret_t sb[$];
  bit   proto_exp = 1'b0;
  int   last_ret  = 0;
  int   rst_edge  = 0;
  int   n_cmp     = 0;
  int   n_bad     = 0;

  function automatic logic [31:0] data_at(input int c);
    return 32'hDEADBEEF ^ (32'(c) << 8);
  endfunction

  // DATA_R changes once per cycle so the captured word pins down the edge.
  always begin
    @(posedge CLK);
    #1;
    DATA_R = data_at(cyc);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every RD_VALID, flags overdue reads.
  always @(negedge CLK) begin
    ret_t e;
    if (RST) begin
      if (RD_VALID) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: RD_VALID=1 tag=%0h, expected no return (edge %0d)", RD_TAG, cyc);
        end else begin
          e = sb.pop_front();
          check("rd_edge", 64'(cyc), 64'(e.due));
          check("rd_tag", 64'(RD_TAG), 64'(e.tag));
          check("rd_data", 64'(RD_DATA), 64'(e.data));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_missing: RD_VALID=0, expected tag %0h due edge %0d (edge %0d)", sb[0].tag, sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  // One cycle: drive inputs, check outputs against the model at negedge,
  // then advance the model to account for the upcoming edge.
  task automatic step(input bit v, input logic [27:0] a, input bit we,
                      input logic [31:0] wd, input logic [TAG_W-1:0] tg, input bit lat);
    bit   can_push;
    req_t h;
    @(posedge CLK);
    #1;
    REQ_VALID       = v;
    REQ_ADDR        = a;
    REQ_WE          = we;
    REQ_WDATA       = wd;
    REQ_TAG         = tg;
    COMMAND_LATCHED = lat;
    @(negedge CLK);
    check("do_act", 64'(DO_ACT), 64'(fq.size() != 0));
    check("req_ready", 64'(REQ_READY), 64'(fq.size() < DEPTH));
    check("busy", 64'(BUSY), 64'(fq.size() != 0 || last_ret > cyc));
    check("proto_err", 64'(PROTO_ERR), 64'(proto_exp));
    check("refresh_strobe", 64'(REFRESH_STROBE), 64'(((cyc - rst_edge) / RP) % 2));
    if (fq.size() != 0) begin
      check("address_req", 64'(ADDRESS_REQ), 64'(fq[0].addr));
      check("we", 64'(WE), 64'(fq[0].we));
      check("data_w", 64'(DATA_W), 64'(fq[0].wdata));
    end
    can_push = v && (fq.size() < DEPTH);
    if (lat) begin
      if (fq.size() == 0) proto_exp = 1'b1;
      else begin
        h = fq.pop_front();
        if (!h.we) begin
          // Latch edge is cyc+1; result captured RD_LAT+1 edges later.
          sb.push_back('{h.tag, data_at(cyc + RD_LAT + 1), cyc + RD_LAT + 2});
          last_ret = cyc + RD_LAT + 2;
        end
      end
    end
    if (can_push) fq.push_back('{a, we, wd, tg});
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge CLK);
    #1;
    RST             = 1'b0;
    REQ_VALID       = 1'b0;
    COMMAND_LATCHED = 1'b0;
    fq.delete();
    sb.delete();
    proto_exp = 1'b0;
    last_ret  = 0;
    repeat (n) @(posedge CLK);
    #1;
    RST      = 1'b1;
    rst_edge = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset then idle.
    do_reset(2);
    idle(3);
    check("rd_data_rst", 64'(RD_DATA), 64'h0);
    check("rd_tag_rst", 64'(RD_TAG), 64'h0);
    check("rd_valid_rst", 64'(RD_VALID), 64'h0);

    // Single read, tag 3.
    step(1'b1, 28'h0ABCDEF, 1'b0, 32'h0, 4'd3, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(8);

    // Write then read, latched on consecutive cycles.
    step(1'b1, 28'h1234567, 1'b1, 32'hCAFEF00D, 4'd1, 1'b0);
    step(1'b1, 28'h0000040, 1'b0, 32'h0, 4'd5, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(8);

    // Fill: fifth push refused, then one pop frees a slot.
    for (int i = 0; i < 5; i++)
      step(1'b1, 28'h0200000 + 28'(i * 16), 1'b0, 32'h1000 + 32'(i), 4'(8 + i), 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 28'h0300ABC, 1'b0, 32'h2000, 4'd13, 1'b0);
    // Drain back-to-back across the pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(8);

    // Latch with an empty FIFO: sticky protocol error.
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(4);

    // Reset two edges after a read latch drops the read.
    do_reset(1);
    step(1'b1, 28'h0444444, 1'b0, 32'h0, 4'd7, 1'b0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    do_reset(1);
    idle(10);

    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
